// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment glyph constants and CA decode function
package seg7_pkg;

   // Active-high gfedcba patterns; the bus carries the inverse.
   localparam logic [6:0] GLYPH_0 = 7'h3F;
   localparam logic [6:0] GLYPH_1 = 7'h06;
   localparam logic [6:0] GLYPH_2 = 7'h5B;
   localparam logic [6:0] GLYPH_3 = 7'h4F;
   localparam logic [6:0] GLYPH_4 = 7'h66;
   localparam logic [6:0] GLYPH_5 = 7'h6D;
   localparam logic [6:0] GLYPH_6 = 7'h7D;
   localparam logic [6:0] GLYPH_7 = 7'h07;
   localparam logic [6:0] GLYPH_8 = 7'h7F;
   localparam logic [6:0] GLYPH_9 = 7'h6F;
   localparam logic [6:0] GLYPH_A = 7'h77;
   localparam logic [6:0] GLYPH_B = 7'h7C;
   localparam logic [6:0] GLYPH_C = 7'h39;
   localparam logic [6:0] GLYPH_D = 7'h5E;
   localparam logic [6:0] GLYPH_E = 7'h79;
   localparam logic [6:0] GLYPH_F = 7'h71;

   localparam logic [15:0][6:0] GLYPHS = {
      GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
      GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
   };

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] AN_IDLE   = 4'hF;

   typedef struct packed {
      logic       legal;
      logic       blank;
      logic [3:0] value;
   } seg_decode_t;

   function automatic seg_decode_t seg7_decode_ca(input logic [6:0] ca);
      seg_decode_t r;
      r = '0;
      if (ca == SEG_BLANK) begin
         r.blank = 1'b1;
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (~ca == GLYPHS[i]) begin
               r.legal = 1'b1;
               r.value = 4'(i);
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational active-low CA to hex value lookup
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] ca,
   output logic       legal,
   output logic       blank,
   output logic [3:0] value
);

   seg_decode_t dec;

   assign dec   = seg7_decode_ca(ca);
   assign legal = dec.legal;
   assign blank = dec.blank;
   assign value = dec.value;

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - samples a multiplexed 7-seg bus and recovers per-digit hex values
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4
)
(
   input  logic        CLK,
   input  logic        Reset,
   input  logic [6:0]  displayCA,
   input  logic [3:0]  displayAN,
   output logic [15:0] DigitVal,
   output logic [3:0]  DigitValid,
   output logic        FrameDone,
   output logic        ScanErr,
   output logic        PatternErr
);

   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX    = CW'(SETTLE_CYCLES);
   localparam logic [CW-1:0] CNT_COMMIT = CW'(SETTLE_CYCLES - 1);

   logic [10:0]   sync1;
   logic [10:0]   s;
   logic [10:0]   prev;
   logic [CW-1:0] cnt;
   logic [3:0]    mask;

   logic [3:0] an;
   logic [6:0] ca;
   logic [3:0] an_low;
   logic       one_low;
   logic       multi_low;
   logic [1:0] idx;
   logic [3:0] mask_next;
   logic       commit;
   logic       dec_legal;
   logic       dec_blank;
   logic [3:0] dec_value;

   assign an = s[10:7];
   assign ca = s[6:0];

   seg7_decode u_decode (
      .ca    (ca),
      .legal (dec_legal),
      .blank (dec_blank),
      .value (dec_value)
   );

   // The count reaches SETTLE_CYCLES-1 exactly once per stable window, so a held value commits once.
   assign commit = (s == prev) && (cnt == CNT_COMMIT);

   assign an_low    = ~an;
   assign one_low   = (an_low != 4'h0) && ((an_low & (an_low - 4'h1)) == 4'h0);
   assign multi_low = (an_low != 4'h0) && !one_low;

   always_comb begin
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (an_low[i]) idx = 2'(i);
      end
   end

   assign mask_next = mask | (4'b0001 << idx);

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         sync1      <= {AN_IDLE, SEG_BLANK};
         s          <= {AN_IDLE, SEG_BLANK};
         prev       <= {AN_IDLE, SEG_BLANK};
         cnt        <= '0;
         mask       <= 4'h0;
         DigitVal   <= 16'h0000;
         DigitValid <= 4'h0;
         FrameDone  <= 1'b0;
         ScanErr    <= 1'b0;
         PatternErr <= 1'b0;
      end else begin
         sync1 <= {displayAN, displayCA};
         s     <= sync1;
         prev  <= s;

         if (s != prev) begin
            cnt <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end

         FrameDone  <= 1'b0;
         ScanErr    <= 1'b0;
         PatternErr <= 1'b0;

         if (commit) begin
            if (multi_low) begin
               ScanErr <= 1'b1;
            end else if (one_low) begin
               if (dec_legal) begin
                  DigitVal[{idx, 2'b00} +: 4] <= dec_value;
                  DigitValid[idx]             <= 1'b1;
               end else begin
                  DigitValid[idx] <= 1'b0;
                  if (!dec_blank) PatternErr <= 1'b1;
               end

               // Blank slots still count toward the frame; garbage does not.
               if (dec_legal || dec_blank) begin
                  if (mask_next == 4'hF) begin
                     FrameDone <= 1'b1;
                     mask      <= 4'h0;
                  end else begin
                     mask <= mask_next;
                  end
               end
            end
         end
      end
   end

endmodule
